tour_cmd_seq: RTL and testbench

- Issues commands to the command processor during a knight's tour.
- On a tour_go pulse, walks the solved move list held in the move memory.
- Each L-shaped knight move becomes two move commands on the processor's command interface: vertical leg first (no fanfare), then horizontal leg (with fanfare).
- Outside a tour it is a transparent mux that passes UART/BLE commands through, and it supplies the response byte sent back over BLE.

---
 rtl/tour_cmd_seq.sv | 148 ++++++++++++++
 tb/tb_tour_cmd_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: turns each one-hot move into a vertical and a
// horizontal command for the command processor, and passes UART commands through when idle.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tour_go,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic [2:0]       dbg_state
);

    // Handshake: cmd is held stable while cmd_rdy is high; the processor consumes it with a
    // one-cycle clr_cmd_rdy strobe, and later reports completion with a send_resp pulse.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_VERT   = 3'd2,
        S_WAIT_V = 3'd3,
        S_HORZ   = 3'd4,
        S_WAIT_H = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);
    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_mv_indx;
    logic [7:0]       r_mv_reg;
    logic             w_last;
    logic [7:0]       w_vhdg;
    logic [7:0]       w_hhdg;
    logic [3:0]       w_vsq;
    logic [3:0]       w_hsq;
    logic [15:0]      w_vert_cmd;
    logic [15:0]      w_horz_cmd;

    assign w_last     = (r_mv_indx == LAST_IDX);
    assign w_vert_cmd = {4'b0010, w_vhdg, w_vsq};
    assign w_horz_cmd = {4'b0011, w_hhdg, w_hsq};
    assign mv_indx    = r_mv_indx;
    assign dbg_state  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mv_indx <= '0;
        end else if (r_state == S_IDLE && tour_go) begin
            r_mv_indx <= '0;
        end else if (r_state == S_WAIT_H && send_resp && !w_last) begin
            r_mv_indx <= r_mv_indx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mv_reg <= '0;
        end else if (r_state == S_FETCH) begin
            r_mv_reg <= move;
        end
    end

    // Lowest set bit wins; an all-zero move degenerates to two 0-square commands.
    always_comb begin
        w_vhdg = HDG_N;
        w_vsq  = 4'd0;
        w_hhdg = HDG_W;
        w_hsq  = 4'd0;
        if (r_mv_reg[0]) begin
            w_vhdg = HDG_N; w_vsq = 4'd2; w_hhdg = HDG_W; w_hsq = 4'd1;
        end else if (r_mv_reg[1]) begin
            w_vhdg = HDG_N; w_vsq = 4'd2; w_hhdg = HDG_E; w_hsq = 4'd1;
        end else if (r_mv_reg[2]) begin
            w_vhdg = HDG_N; w_vsq = 4'd1; w_hhdg = HDG_W; w_hsq = 4'd2;
        end else if (r_mv_reg[3]) begin
            w_vhdg = HDG_S; w_vsq = 4'd1; w_hhdg = HDG_W; w_hsq = 4'd2;
        end else if (r_mv_reg[4]) begin
            w_vhdg = HDG_S; w_vsq = 4'd2; w_hhdg = HDG_W; w_hsq = 4'd1;
        end else if (r_mv_reg[5]) begin
            w_vhdg = HDG_S; w_vsq = 4'd2; w_hhdg = HDG_E; w_hsq = 4'd1;
        end else if (r_mv_reg[6]) begin
            w_vhdg = HDG_S; w_vsq = 4'd1; w_hhdg = HDG_E; w_hsq = 4'd2;
        end else if (r_mv_reg[7]) begin
            w_vhdg = HDG_N; w_vsq = 4'd1; w_hhdg = HDG_E; w_hsq = 4'd2;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (tour_go)     w_next_state = S_FETCH;
            S_FETCH:                   w_next_state = S_VERT;
            S_VERT:   if (clr_cmd_rdy) w_next_state = S_WAIT_V;
            S_WAIT_V: if (send_resp)   w_next_state = S_HORZ;
            S_HORZ:   if (clr_cmd_rdy) w_next_state = S_WAIT_H;
            S_WAIT_H: if (send_resp)   w_next_state = w_last ? S_IDLE : S_FETCH;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    // UART traffic only reaches the processor while idle; during a tour it waits.
    always_comb begin
        cmd              = w_vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'h5A;
        case (r_state)
            S_IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
            end
            S_VERT:   cmd_rdy = 1'b1;
            S_WAIT_V: resp    = 8'hA5;
            S_HORZ: begin
                cmd     = w_horz_cmd;
                cmd_rdy = 1'b1;
            end
            S_WAIT_H: begin
                cmd  = w_horz_cmd;
                resp = w_last ? 8'h5A : 8'hA5;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: pass-through, move decode, full tour, lockout and
// mid-tour reset, with a small move memory model and hand-computed command table.
module tb_tour_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tour_go;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int ncmds  = 0;

    logic [7:0]  mem   [0:31];
    logic [15:0] ev_tab[0:23];
    logic [15:0] eh_tab[0:23];

    always #5 clk = ~clk;

    assign move = mem[mv_indx];

    tour_cmd_seq #(.NUM_MOVES(24), .IDX_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tour_go          (tour_go),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .resp             (resp),
        .dbg_state        (dbg_state)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the FETCH state has been entered; leaves the DUT past WAIT_H.
    task automatic run_move(input int i, input logic go, input logic both);
        #1;
        chk("fetch_state", 16'(dbg_state), 16'd1);
        chk("fetch_rdy", 16'(cmd_rdy), 16'd0);
        chk("fetch_idx", 16'(mv_indx), 16'(i));
        tick();
        chk("vert_cmd", cmd, ev_tab[i]);
        chk("vert_rdy", 16'(cmd_rdy), 16'd1);
        chk("vert_resp", 16'(resp), 16'h5A);
        clr_cmd_rdy = 1'b1;
        send_resp   = both;
        #1;
        chk("vert_uart_clr", 16'(clr_cmd_rdy_UART), 16'd0);
        ncmds++;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        #1;
        chk("waitv_rdy", 16'(cmd_rdy), 16'd0);
        chk("waitv_cmd", cmd, ev_tab[i]);
        chk("waitv_resp", 16'(resp), 16'hA5);
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        #1;
        chk("horz_cmd", cmd, eh_tab[i]);
        chk("horz_rdy", 16'(cmd_rdy), 16'd1);
        clr_cmd_rdy = 1'b1;
        #1;
        chk("horz_uart_clr", 16'(clr_cmd_rdy_UART), 16'd0);
        ncmds++;
        tick();
        clr_cmd_rdy = 1'b0;
        #1;
        chk("waith_rdy", 16'(cmd_rdy), 16'd0);
        chk("waith_resp", 16'(resp), (i == 23) ? 16'h5A : 16'hA5);
        send_resp = 1'b1;
        tour_go   = go;
        tick();
        send_resp = 1'b0;
        tour_go   = 1'b0;
    endtask

    initial begin
        logic [7:0]  pats [0:8];
        logic [15:0] pv   [0:8];
        logic [15:0] ph   [0:8];
        pats = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
        pv   = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1, 16'h27F2, 16'h27F2, 16'h27F1, 16'h2001, 16'h2000};
        ph   = '{16'h33F1, 16'h3BF1, 16'h33F2, 16'h33F2, 16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2, 16'h33F0};
        for (int k = 0; k < 32; k++) mem[k] = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            mem[k] = pats[k]; ev_tab[k] = pv[k]; eh_tab[k] = ph[k];
        end
        mem[9]  = 8'hC0; ev_tab[9]  = 16'h27F1; eh_tab[9]  = 16'h3BF2;
        mem[10] = 8'h0A; ev_tab[10] = 16'h2002; eh_tab[10] = 16'h3BF1;
        for (int k = 11; k < 24; k++) begin
            mem[k] = pats[(k - 11) % 9]; ev_tab[k] = pv[(k - 11) % 9]; eh_tab[k] = ph[(k - 11) % 9];
        end

        rst_n        = 1'b0;
        tour_go      = 1'b0;
        cmd_UART     = 16'h1234;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b1;
        send_resp    = 1'b0;
        #3;
        chk("rst_state", 16'(dbg_state), 16'd0);
        chk("rst_idx", 16'(mv_indx), 16'd0);
        chk("rst_cmd", cmd, 16'h1234);
        chk("rst_rdy", 16'(cmd_rdy), 16'd1);
        chk("rst_uart_clr", 16'(clr_cmd_rdy_UART), 16'd1);
        chk("rst_resp", 16'(resp), 16'h5A);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        cmd_UART = 16'h0000;
        clr_cmd_rdy = 1'b0;
        #1;
        chk("pt_cmd", cmd, 16'h0000);
        chk("pt_rdy", 16'(cmd_rdy), 16'd1);
        chk("pt_uart_clr0", 16'(clr_cmd_rdy_UART), 16'd0);
        chk("pt_resp", 16'(resp), 16'h5A);
        clr_cmd_rdy = 1'b1;
        #1;
        chk("pt_uart_clr1", 16'(clr_cmd_rdy_UART), 16'd1);
        clr_cmd_rdy  = 1'b0;
        cmd_rdy_UART = 1'b0;
        #1;
        chk("pt_rdy_off", 16'(cmd_rdy), 16'd0);

        // Full tour with a UART command pending throughout and stray tour_go pulses.
        cmd_UART     = 16'hFFFF;
        cmd_rdy_UART = 1'b1;
        tick();
        tour_go = 1'b1;
        tick();
        tour_go = 1'b0;
        for (int i = 0; i < 24; i++) begin
            run_move(i, (i == 4 || i == 12), (i == 2 || i == 7));
        end
        #1;
        chk("end_cmds", 16'(ncmds), 16'd48);
        chk("end_idx", 16'(mv_indx), 16'd23);
        chk("end_state", 16'(dbg_state), 16'd0);
        chk("end_cmd", cmd, 16'hFFFF);
        chk("end_rdy", 16'(cmd_rdy), 16'd1);
        chk("end_resp", 16'(resp), 16'h5A);
        tick();
        chk("idle_stays", 16'(dbg_state), 16'd0);

        // Second tour, reset in WAIT_H of move 10, then a clean restart.
        cmd_rdy_UART = 1'b0;
        tour_go = 1'b1;
        tick();
        tour_go = 1'b0;
        for (int i = 0; i < 10; i++) run_move(i, 1'b0, 1'b0);
        tick();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        #1;
        chk("m10_state", 16'(dbg_state), 16'd5);
        chk("m10_idx", 16'(mv_indx), 16'd10);
        chk("m10_resp", 16'(resp), 16'hA5);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 16'(dbg_state), 16'd0);
        chk("arst_idx", 16'(mv_indx), 16'd0);
        chk("arst_resp", 16'(resp), 16'h5A);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 16'(dbg_state), 16'd0);
        tour_go = 1'b1;
        tick();
        tour_go = 1'b0;
        run_move(0, 1'b0, 1'b0);
        #1;
        chk("restart_idx", 16'(mv_indx), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
